uart_rx_deframer: RTL and testbench
===================================

// Module: uart_rx_deframer
// PURPOSE
//  Host-side UART receiver: deserialises the SoC's io_uart_txd line on the FPGA fabric, validates
//  framing/parity and buffers bytes in a small FIFO with a valid/ready output. Sits beside the SoC
//  in the FPGA top, clocked by the clk_wiz core clock. Feeds on-fabric loopback checks and a debug bridge.
// PARAMETERS
//  CLK_DIV     27  core-clock cycles per 1/16-bit tick (50 MHz / (16*115200)); must be >= 2
//  DATA_BITS   8   payload bits per frame, 5..8, LSB first
//  PARITY      0   0 none, 1 odd, 2 even
//  FIFO_DEPTH  8   receive FIFO entries, power of two, >= 2
// PORTS
//  io_axiClk        in   1                      core clock, single domain
//  io_asyncResetn   in   1                      asynchronous, active-low reset
//  io_uart_rxd      in   1                      serial input, idle high, asynchronous to io_axiClk
//  rx_data          out  DATA_BITS              FIFO head byte
//  rx_valid         out  1                      FIFO non-empty
//  rx_ready         in   1                      consumer pops head when rx_valid & rx_ready
//  rx_frame_err     out  1                      1-cycle pulse: stop bit sampled low
//  rx_parity_err    out  1                      1-cycle pulse: parity mismatch
//  rx_overrun       out  1                      1-cycle pulse: byte dropped, FIFO full
//  fifo_level       out  $clog2(FIFO_DEPTH)+1   current occupancy
// BEHAVIOUR
//  - Reset: all outputs 0; synchroniser flops preset to 1; FSM IDLE; tick counter 0; FIFO empty.
//    Reset mid-frame aborts the frame; no partial byte is pushed.
//  - io_uart_rxd passes through 2-FF synchroniser; all logic uses the synchronised rxd_s.
//  - Tick counter counts 0..CLK_DIV-1 and emits one tick at wrap. It is held at 0 in IDLE and
//    restarts on start detection, so the frame is phase-aligned to the falling edge.
//  - Per-bit sample counter 0..15 advances on each tick. Bit value = majority of samples 7, 8, 9.
//  - FSM:
//    IDLE   -> START   on rxd_s falling edge (1 then 0)
//    START  -> IDLE    if majority at sample 9 is 1 (glitch; nothing reported)
//    START  -> DATA    otherwise, at sample 15
//    DATA   shifts DATA_BITS bits LSB first; after the last bit -> PARITY, or -> STOP if PARITY=0
//    PARITY compares received bit against computed parity, stores the mismatch, then -> STOP
//    STOP   evaluated at sample 9:
//           stop=1 & parity ok  -> push byte, -> IDLE (next start accepted from sample 10)
//           stop=1 & parity bad -> pulse rx_parity_err, drop byte, -> IDLE
//           stop=0              -> pulse rx_frame_err, drop byte, -> BREAK (frame error wins
//                                  over parity error; only rx_frame_err pulses)
//    BREAK  -> IDLE    once rxd_s has been 1 for 16 consecutive ticks (a held-low break counts
//           as one frame error)
//  - Push latency: byte is visible on rx_data/rx_valid on the 2nd io_axiClk edge after the
//    stop-bit sample-9 tick when the FIFO was empty (first-word fall-through).
//  - FIFO:
//    push when full and no pop -> byte dropped, rx_overrun pulses, contents unchanged
//    push and pop in the same cycle when full -> both succeed, level unchanged, no overrun
//    pop when empty -> ignored; rx_data holds its last value
//    pointers wrap modulo FIFO_DEPTH; fifo_level is exact 0..FIFO_DEPTH
//  - Error pulses are exactly one cycle and never overlap for the same frame.
// STRUCTURE
//  - Shared package uart_pkg holds:
//    rx_state_t enum {IDLE, START, DATA, PARITY, STOP, BREAK}
//    parity_e {PAR_NONE, PAR_ODD, PAR_EVEN}
//    localparam OVERSAMPLE = 16, MAJ_LO = 7, MAJ_HI = 9
//  - One sub-module: uart_sync_fifo (WIDTH, DEPTH; push/pop/full/empty/level; first-word
//    fall-through). Synchroniser, tick generator and FSM live in this module.
// TESTING
//  - CLK_DIV=4, PARITY=0: send 0xA5 at 64 clk/bit -> rx_data=0xA5, rx_valid=1, no error pulses.
//  - 1-tick low glitch (3 clk) on idle line -> FSM returns to IDLE, nothing pushed, no errors.
//  - 0x3C with stop bit driven 0 -> one rx_frame_err pulse, fifo_level=0. Hold line low for
//    5 bit-times, then release and send 0x11 -> 0x11 received, no further errors.
//  - PARITY=2: send 0x07 with parity bit 0 (wrong) -> rx_parity_err pulses, nothing pushed.
//    Same byte with parity bit 1 -> 0x07 pushed.
//  - rx_ready=0, send 9 bytes 0x01..0x09 with FIFO_DEPTH=8 -> fifo_level=8, rx_overrun pulses
//    once, then draining yields 0x01..0x08. Pop and push in the same cycle at full -> level stays 8.
//  - Assert io_asyncResetn low during data bit 4 of 0xFF -> all outputs 0. After release,
//    0x5A sent -> exactly 0x5A received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} rx_state_t;
   typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_e;

   localparam int OVERSAMPLE = 16;
   localparam int MAJ_LO     = 7;
   localparam int MAJ_HI     = 9;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word fall-through receive FIFO; a pop on empty leaves data_o at the last popped word.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW    = $clog2(DEPTH);
   localparam int LVL_W = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] last_q;
   logic [AW-1:0]    wr_q, rd_q;
   logic [LVL_W-1:0] count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == LVL_W'(DEPTH));
   assign level_o = count_q;
   assign do_pop  = pop_i & ~empty_o;
   // A push at full is only accepted when a pop frees the head slot in the same cycle.
   assign do_push = push_i & (~full_o | do_pop);
   assign data_o  = empty_o ? last_q : mem_q[rd_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         last_q  <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= wr_q + 1'b1;
         end
         if (do_pop) begin
            last_q <= mem_q[rd_q];
            rd_q   <= rd_q + 1'b1;
         end
         count_q <= count_q + LVL_W'(do_push) - LVL_W'(do_pop);
      end
   end

endmodule

// File: rtl/uart_rx_deframer.sv
// 16x oversampling UART receiver with majority voting, parity/framing checks and a FWFT FIFO.
//
// state  | meaning
// IDLE   | line idle, waiting for a falling edge on rxd_s
// START  | validating the start bit, glitches fall back to IDLE
// DATA   | shifting payload bits LSB first
// PARITY | sampling the parity bit and recording a mismatch
// STOP   | sampling the stop bit, push or report the error
// BREAK  | after a framing error, waiting for 16 ticks of idle line
module uart_rx_deframer #(
   parameter int CLK_DIV    = 27,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          io_axiClk,
   input  logic                          io_asyncResetn,
   input  logic                          io_uart_rxd,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic                          rx_frame_err,
   output logic                          rx_parity_err,
   output logic                          rx_overrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   import uart_pkg::*;

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   rx_state_t              state_q;
   logic                   sync1_q, rxd_s_q, rxd_prev_q;
   logic [DIV_W-1:0]       div_q;
   logic [3:0]             samp_q;
   logic [3:0]             bit_q;
   logic                   s7_q, s8_q;
   logic [DATA_BITS-1:0]   shift_q, push_data_q;
   logic                   par_bad_q, push_q;
   logic                   frame_err_q, parity_err_q, overrun_q;
   logic                   tick, at_mid, at_end, fall, maj, exp_par;
   logic                   fifo_full, fifo_empty;

   assign tick    = (state_q != IDLE) && (div_q == DIV_W'(CLK_DIV - 1));
   assign at_mid  = tick && (samp_q == 4'(MAJ_HI));
   assign at_end  = tick && (samp_q == 4'(OVERSAMPLE - 1));
   assign fall    = rxd_prev_q & ~rxd_s_q;
   assign maj     = majority3(s7_q, s8_q, rxd_s_q);
   assign exp_par = (PARITY == int'(PAR_ODD)) ? ~(^shift_q) : (^shift_q);

   always_ff @(posedge io_axiClk or negedge io_asyncResetn) begin
      if (!io_asyncResetn) begin
         state_q      <= IDLE;
         sync1_q      <= 1'b1;
         rxd_s_q      <= 1'b1;
         rxd_prev_q   <= 1'b1;
         div_q        <= '0;
         samp_q       <= '0;
         bit_q        <= '0;
         s7_q         <= 1'b1;
         s8_q         <= 1'b1;
         shift_q      <= '0;
         push_data_q  <= '0;
         par_bad_q    <= 1'b0;
         push_q       <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         sync1_q      <= io_uart_rxd;
         rxd_s_q      <= sync1_q;
         rxd_prev_q   <= rxd_s_q;
         push_q       <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overrun_q    <= push_q & fifo_full & ~rx_ready;

         if (state_q == IDLE || tick) div_q <= '0;
         else                         div_q <= div_q + 1'b1;

         if (tick) begin
            samp_q <= samp_q + 1'b1;
            if (samp_q == 4'(MAJ_LO))     s7_q <= rxd_s_q;
            if (samp_q == 4'(MAJ_LO + 1)) s8_q <= rxd_s_q;
         end

         case (state_q)
            IDLE: begin
               if (fall) begin
                  state_q   <= START;
                  samp_q    <= '0;
                  bit_q     <= '0;
                  par_bad_q <= 1'b0;
               end
            end
            START: begin
               if (at_mid && maj) state_q <= IDLE;
               else if (at_end)   state_q <= DATA;
            end
            DATA: begin
               if (at_mid) shift_q <= {maj, shift_q[DATA_BITS-1:1]};
               if (at_end) begin
                  if (bit_q == 4'(DATA_BITS - 1))
                     state_q <= (PARITY == 0) ? STOP : uart_pkg::PARITY;
                  else
                     bit_q <= bit_q + 1'b1;
               end
            end
            uart_pkg::PARITY: begin
               if (at_mid) par_bad_q <= (maj != exp_par);
               if (at_end) state_q <= STOP;
            end
            STOP: begin
               if (at_mid) begin
                  if (!maj) begin
                     frame_err_q <= 1'b1;
                     samp_q      <= '0;
                     state_q     <= BREAK;
                  end else if (par_bad_q) begin
                     parity_err_q <= 1'b1;
                     state_q      <= IDLE;
                  end else begin
                     push_q      <= 1'b1;
                     push_data_q <= shift_q;
                     state_q     <= IDLE;
                  end
               end
            end
            BREAK: begin
               // samp_q doubles as the run length of consecutive high ticks.
               if (tick) begin
                  if (!rxd_s_q)                              samp_q  <= '0;
                  else if (samp_q == 4'(OVERSAMPLE - 1))     state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   uart_sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (io_axiClk),
      .rst_ni  (io_asyncResetn),
      .push_i  (push_q),
      .data_i  (push_data_q),
      .pop_i   (rx_ready),
      .data_o  (rx_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign rx_valid      = ~fifo_empty;
   assign rx_frame_err  = frame_err_q;
   assign rx_parity_err = parity_err_q;
   assign rx_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench: two receivers (no parity / even parity) driven with directed serial frames.
module tb_uart_rx_deframer;

   localparam int BIT_CLK = 64;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rxd_n, rxd_p, ready_n, ready_p;
   logic [7:0] data_n, data_p;
   logic       valid_n, valid_p, ferr_n, ferr_p, perr_n, perr_p, ovr_n, ovr_p;
   logic [3:0] lvl_n, lvl_p;

   int n_checks = 0;
   int n_fail   = 0;
   int cnt_ferr_n = 0, cnt_perr_n = 0, cnt_ovr_n = 0, rx_cnt_n = 0;
   int cnt_ferr_p = 0, cnt_perr_p = 0, cnt_ovr_p = 0, rx_cnt_p = 0;
   logic [7:0] exp_n[$];
   logic [7:0] exp_p[$];

   always #5 clk = ~clk;

   uart_rx_deframer #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(8)) dut_n (
      .io_axiClk(clk), .io_asyncResetn(rst_n), .io_uart_rxd(rxd_n),
      .rx_data(data_n), .rx_valid(valid_n), .rx_ready(ready_n),
      .rx_frame_err(ferr_n), .rx_parity_err(perr_n), .rx_overrun(ovr_n),
      .fifo_level(lvl_n));

   uart_rx_deframer #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(8)) dut_p (
      .io_axiClk(clk), .io_asyncResetn(rst_n), .io_uart_rxd(rxd_p),
      .rx_data(data_p), .rx_valid(valid_p), .rx_ready(ready_p),
      .rx_frame_err(ferr_p), .rx_parity_err(perr_p), .rx_overrun(ovr_p),
      .fifo_level(lvl_p));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic put(input bit sel, input logic v);
      if (sel) rxd_p = v;
      else     rxd_n = v;
   endtask

   task automatic send(input bit sel, input logic [7:0] d, input bit has_par,
                       input bit pbit, input bit stop);
      @(negedge clk);
      put(sel, 1'b0);
      repeat (BIT_CLK) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         put(sel, d[i]);
         repeat (BIT_CLK) @(negedge clk);
      end
      if (has_par) begin
         put(sel, pbit);
         repeat (BIT_CLK) @(negedge clk);
      end
      put(sel, stop);
      repeat (BIT_CLK) @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: a transfer happens on the next posedge when valid & ready; pulses counted per cycle.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clk);
         #1;
         if (ferr_n) cnt_ferr_n++;
         if (perr_n) cnt_perr_n++;
         if (ovr_n)  cnt_ovr_n++;
         if (ferr_p) cnt_ferr_p++;
         if (perr_p) cnt_perr_p++;
         if (ovr_p)  cnt_ovr_p++;
         if (valid_n === 1'b1 && ready_n === 1'b1) begin
            rx_cnt_n++;
            if (exp_n.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL sb_n: unexpected byte %0h, none expected", data_n);
            end else begin
               e = exp_n.pop_front();
               check("sb_n_byte", 32'(data_n), 32'(e));
            end
         end
         if (valid_p === 1'b1 && ready_p === 1'b1) begin
            rx_cnt_p++;
            if (exp_p.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL sb_p: unexpected byte %0h, none expected", data_p);
            end else begin
               e = exp_p.pop_front();
               check("sb_p_byte", 32'(data_p), 32'(e));
            end
         end
      end
   end

   initial begin
      #3_000_000;
      n_fail++;
      $display("FAIL watchdog: time limit reached, got running, expected finished");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      int waited;
      rst_n = 1'b0; rxd_n = 1'b1; rxd_p = 1'b1; ready_n = 1'b0; ready_p = 1'b0;
      idle(3);
      #1;
      check("rst_data",  32'(data_n),  32'h0);
      check("rst_valid", 32'(valid_n), 32'h0);
      check("rst_ferr",  32'(ferr_n),  32'h0);
      check("rst_perr",  32'(perr_n),  32'h0);
      check("rst_ovr",   32'(ovr_n),   32'h0);
      check("rst_level", 32'(lvl_n),   32'h0);
      check("rst_valid_p", 32'(valid_p), 32'h0);
      @(negedge clk);
      rst_n = 1'b1; ready_n = 1'b1; ready_p = 1'b1;
      idle(40);

      // Plain frame
      exp_n.push_back(8'hA5);
      send(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
      idle(32);
      check("a5_rx_count", 32'(rx_cnt_n), 32'd1);
      check("a5_ferr", 32'(cnt_ferr_n), 32'd0);
      check("a5_perr", 32'(cnt_perr_n), 32'd0);

      // 3-cycle glitch on idle line
      @(negedge clk); rxd_n = 1'b0;
      idle(3);        rxd_n = 1'b1;
      idle(2 * BIT_CLK + 32);
      check("glitch_rx_count", 32'(rx_cnt_n), 32'd1);
      check("glitch_ferr", 32'(cnt_ferr_n), 32'd0);
      check("glitch_level", 32'(lvl_n), 32'd0);

      // Framing error followed by a held-low break
      send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
      idle(5 * BIT_CLK);
      check("brk_ferr", 32'(cnt_ferr_n), 32'd1);
      check("brk_level", 32'(lvl_n), 32'd0);
      rxd_n = 1'b1;
      idle(2 * BIT_CLK);
      exp_n.push_back(8'h11);
      send(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
      idle(32);
      check("post_brk_rx_count", 32'(rx_cnt_n), 32'd2);
      check("post_brk_ferr", 32'(cnt_ferr_n), 32'd1);
      check("post_brk_perr", 32'(cnt_perr_n), 32'd0);

      // Even parity: 0x07 has three ones so the correct parity bit is 1
      send(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
      idle(32);
      check("par_bad_perr", 32'(cnt_perr_p), 32'd1);
      check("par_bad_level", 32'(lvl_p), 32'd0);
      check("par_bad_ferr", 32'(cnt_ferr_p), 32'd0);
      exp_p.push_back(8'h07);
      send(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
      idle(32);
      check("par_ok_rx_count", 32'(rx_cnt_p), 32'd1);
      check("par_ok_perr", 32'(cnt_perr_p), 32'd1);

      // Overrun: nine bytes into an eight-entry FIFO with the consumer stalled
      @(negedge clk); ready_n = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         if (i <= 8) exp_n.push_back(8'(i));
         send(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
         idle(16);
      end
      check("ovr_level", 32'(lvl_n), 32'd8);
      check("ovr_count", 32'(cnt_ovr_n), 32'd1);

      // Pop exactly in the cycle the next byte is pushed at full.
      // Start on N0; push_q is high in the cycle after posedge 619, so ready is driven at N619.
      exp_n.push_back(8'h0A);
      fork
         send(1'b0, 8'h0A, 1'b0, 1'b0, 1'b1);
         begin
            repeat (620) @(negedge clk);
            ready_n = 1'b1;
            @(negedge clk);
            ready_n = 1'b0;
         end
      join
      idle(16);
      check("pushpop_level", 32'(lvl_n), 32'd8);
      check("pushpop_ovr", 32'(cnt_ovr_n), 32'd1);

      @(negedge clk); ready_n = 1'b1;
      waited = 0;
      while (valid_n === 1'b1 && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      #1;
      check("drain_timeout", 32'(waited < 500), 32'd1);
      check("drain_queue", 32'(exp_n.size()), 32'd0);
      check("drain_rx_count", 32'(rx_cnt_n), 32'd11);
      check("drain_level", 32'(lvl_n), 32'd0);

      // Reset during data bit 4 of 0xFF (bit 4 occupies N320..N383 after the start negedge)
      fork
         send(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
         begin
            repeat (353) @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("midrst_data",  32'(data_n),  32'h0);
            check("midrst_valid", 32'(valid_n), 32'h0);
            check("midrst_level", 32'(lvl_n),   32'h0);
            check("midrst_ferr",  32'(ferr_n),  32'h0);
            check("midrst_perr",  32'(perr_n),  32'h0);
            check("midrst_ovr",   32'(ovr_n),   32'h0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
         end
      join
      idle(BIT_CLK);
      check("midrst_no_push", 32'(rx_cnt_n), 32'd11);
      exp_n.push_back(8'h5A);
      send(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
      idle(32);
      check("final_rx_count", 32'(rx_cnt_n), 32'd12);
      check("final_queue_n", 32'(exp_n.size()), 32'd0);
      check("final_queue_p", 32'(exp_p.size()), 32'd0);
      check("final_ferr", 32'(cnt_ferr_n), 32'd1);
      check("final_perr", 32'(cnt_perr_n), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
